serial_deserializer: RTL and testbench
======================================

# serial_deserializer

- Bit-serial receiver: collects `WIDTH` bits from a valid/ready serial stream and assembles them into a parallel word.
- Presents each word on a valid/ready parallel output, with one internal word of buffering so serial intake continues while the output is back-pressured.
- Receive-side counterpart of the parallel-load shift register used for serial transmit.
- Sits between a bit-serial link front end and word-wide datapath logic.

## Interface
- `WIDTH`, 8, data word width in bits (≥2)
- `MSB_FIRST`, 1, 1: first received bit lands in `data_out[WIDTH-1]`; 0: first bit lands in `data_out[0]`
- `clock`  input  1  sole clock, all state updates on posedge
- `reset_L`  input  1  asynchronous, active-low reset
- `serial_in`  input  1  serial data bit
- `serial_valid`  input  1  `serial_in` valid this cycle
- `serial_ready`  output  1  block accepts a bit this cycle
- `abort`  input  1  synchronous; discard any partially assembled or stalled word
- `data_out`  output  WIDTH  assembled word (registered)
- `data_valid`  output  1  `data_out` holds an undelivered word
- `data_ready`  input  1  consumer takes `data_out` this cycle
- `parity_err`  output  1  per-word parity flag, qualified by `data_valid`
- `bit_count`  output  $clog2(WIDTH+1)  bits accepted in current frame

## Operation
- Bit accepted on a posedge where `serial_valid && serial_ready`.
- Word delivered on a posedge where `data_valid && data_ready`.
- Internal storage:
  - Assembly shift register `asm` plus `bit_count`.
  - Output register drives `data_out`, `parity_err`, `data_valid`.
- `MSB_FIRST=1`: `asm <= {asm[WIDTH-2:0], serial_in}`.
- `MSB_FIRST=0`: `asm <= {serial_in, asm[WIDTH-1:1]}`.
- States:
  - COLLECT: accepts data bits; `bit_count` 0..WIDTH-1.
  - PARITY: only with the parity macro; accepts one parity bit.
  - STALL: complete word held in `asm`; `serial_ready`=0.
- `serial_ready` = (state != STALL), decoded from state.
- End of frame is the final data bit, or the parity bit when the parity macro is compiled in.
- On the end-of-frame accept:
  - If the output register is free or being drained in the same cycle, the word loads into the output register, `data_valid`<=1, `bit_count`<=0, state<=COLLECT.
  - Otherwise the word stays in `asm` and state<=STALL.
- In STALL, on the edge where the output drains: `asm` moves into the output register, `data_valid` stays 1, state<=COLLECT, `bit_count`<=0.
- `abort`:
  - On the next edge, `bit_count`<=0 and state<=COLLECT.
  - Discards a partial word and any STALL-held word.
  - Does not touch the output register or `data_valid`.
  - A bit accepted in the same cycle as `abort` is dropped; `abort` wins.
- `data_ready` while `data_valid`=0 has no effect.
- `bit_count` increments by exactly 1 per accepted bit.
- `bit_count` never exceeds WIDTH: it reaches WIDTH only in PARITY state.

## Timing
- Reset values, applied asynchronously while `reset_L`=0:
  - state=COLLECT, `bit_count`=0, `asm`=0.
  - `data_out`=0, `data_valid`=0, `parity_err`=0.
  - `serial_ready`=1. Inputs are ignored until the first posedge after `reset_L` rises.
- Reset mid-word or with a pending output: everything is lost immediately, with no clock required.
- Latency: `data_valid` rises in the cycle after the end-of-frame bit is accepted.
- Throughput: one bit per cycle sustained when `data_ready` is held at 1.
- A new word is presented in the same cycle as the drain edge of the previous one.
- Back-pressure: two full words are buffered (output register plus `asm`) before `serial_ready` drops.
- `serial_ready` returns to 1 in the cycle after the output drains.
- `data_out` and `parity_err` are stable while `data_valid`=1 and `data_ready`=0.

## Configuration
- `SERIAL_DESER_PARITY_EN` defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, accepted in PARITY state.
  - `parity_err` = XOR of all WIDTH+1 frame bits, latched with the word.
  - A mismatched word is still delivered, with `parity_err`=1.
- `SERIAL_DESER_PARITY_EN` undefined:
  - PARITY state does not exist; frame is WIDTH bits.
  - `parity_err` is tied to 0.
  - `bit_count` never reaches WIDTH.

## Test plan
All scenarios use WIDTH=8; scenarios 1–5 have the parity macro off.
1. `MSB_FIRST=1`, `data_ready`=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> `data_out`=8'hA5, `data_valid` high for exactly one cycle, in the cycle after the 8th bit.
2. Bits 1,1,0,0,0,0,0,0 -> `data_out`=8'hC0 with `MSB_FIRST=1`, 8'h03 with `MSB_FIRST=0`.
3. Back-pressure:
   - Stimulus: `data_ready`=0, stream words 8'h11, 8'h22, then start 8'h33.
   - After bit 16: `serial_ready`=0, `data_out`=8'h11.
   - Raise `data_ready`: 8'h11 taken, 8'h22 valid on the next cycle, `serial_ready`=1, 8'h33 completes intact.
4. Abort after 5 bits, then 8 bits of 8'h3C -> only 8'h3C is delivered. Abort asserted together with a valid bit -> that bit is not counted (`bit_count` reads 0 next cycle).
5. Reset mid-operation: `reset_L` low after 4 bits, with 8'h5A pending in the output register -> immediately `data_valid`=0, `data_out`=0, `bit_count`=0. After release, a full word 8'hFF is delivered correctly.
6. Parity, macro on:
   - 8'hA5 followed by parity bit 0 -> `parity_err`=0.
   - 8'hA5 followed by parity bit 1 -> `parity_err`=1.
   - 8'h01 followed by parity bit 1 -> `parity_err`=0.
   - In all cases `data_valid` rises the cycle after the 9th bit.

Source files
------------

// File: rtl/serial_deserializer_if.sv
// Bundle of the serial intake and parallel output handshakes of serial_deserializer.
// slave is the deserializer side; master is the link front end / word consumer side.
interface serial_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             serial_in;
  logic             serial_valid;
  logic             serial_ready;
  logic             abort;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             parity_err;
  logic [CW-1:0]    bit_count;

  modport slave (
    input  serial_in, serial_valid, abort, data_ready,
    output serial_ready, data_out, data_valid, parity_err, bit_count
  );

  modport master (
    output serial_in, serial_valid, abort, data_ready,
    input  serial_ready, data_out, data_valid, parity_err, bit_count
  );
endinterface

// File: rtl/serial_deserializer.sv
// Bit-serial receiver assembling WIDTH-bit words, with one word of buffering behind the output register.
// Optional even-parity bit per frame when SERIAL_DESER_PARITY_EN is defined.
module serial_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clock,
  input  logic                  reset_L,
  serial_deserializer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {COLLECT = 2'd0, PARITY = 2'd1, STALL = 2'd2} state_t;
`else
  typedef enum logic [0:0] {COLLECT = 1'b0, STALL = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             stallPerr_q, stallPerr_d;

  logic             accept;
  logic             drain;
  logic             outFree;
  logic [WIDTH-1:0] shifted;
  logic             frameEnd;
  logic [WIDTH-1:0] frameWord;
  logic             framePerr;

  assign accept  = bus.serial_valid && bus.serial_ready;
  assign drain   = valid_q && bus.data_ready;
  assign outFree = !valid_q || drain;

  generate
    if (MSB_FIRST != 0) begin : gMsbFirst
      assign shifted = {asm_q[WIDTH-2:0], bus.serial_in};
    end else begin : gLsbFirst
      assign shifted = {bus.serial_in, asm_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state: frame collection, then either load the output register or park the word in asm.
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    stallPerr_d = stallPerr_q;
    frameEnd    = 1'b0;
    frameWord   = asm_q;
    framePerr   = 1'b0;

    if (drain) begin
      valid_d = 1'b0;
    end

    if (bus.abort) begin
      state_d = COLLECT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            asm_d = shifted;
            if (cnt_q == LAST_DATA) begin
`ifdef SERIAL_DESER_PARITY_EN
              state_d = PARITY;
              cnt_d   = cnt_q + CW'(1);
`else
              frameEnd  = 1'b1;
              frameWord = shifted;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
`ifdef SERIAL_DESER_PARITY_EN
        PARITY: begin
          if (accept) begin
            frameEnd  = 1'b1;
            frameWord = asm_q;
            framePerr = ^{asm_q, bus.serial_in};
          end
        end
`endif
        STALL: begin
          if (drain) begin
            out_d   = asm_q;
            perr_d  = stallPerr_q;
            valid_d = 1'b1;
            state_d = COLLECT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = COLLECT;
        end
      endcase

      // A drain on this same edge frees the output register for the new word.
      if (frameEnd) begin
        cnt_d = '0;
        if (outFree) begin
          out_d   = frameWord;
          perr_d  = framePerr;
          valid_d = 1'b1;
          state_d = COLLECT;
        end else begin
          stallPerr_d = framePerr;
          state_d     = STALL;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= COLLECT;
      asm_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      stallPerr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      stallPerr_q <= stallPerr_d;
    end
  end

  assign bus.serial_ready = (state_q != STALL);
  assign bus.data_out     = out_q;
  assign bus.data_valid   = valid_q;
  assign bus.parity_err   = perr_q;
  assign bus.bit_count    = cnt_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: MSB-first and LSB-first instances share one stimulus,
// checked by directed scenarios and a queue-based frame model under random traffic.
module tb_serial_deserializer;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = PAR ? W + 1 : W;

  logic clock = 1'b0;
  logic reset_L = 1'b1;
  logic sv = 1'b0, sbit = 1'b0, ab = 1'b0, dr = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  serial_deserializer_if #(.WIDTH(W)) ifA ();
  serial_deserializer_if #(.WIDTH(W)) ifB ();

  assign ifA.serial_in = sbit;  assign ifA.serial_valid = sv;
  assign ifA.abort     = ab;    assign ifA.data_ready   = dr;
  assign ifB.serial_in = sbit;  assign ifB.serial_valid = sv;
  assign ifB.abort     = ab;    assign ifB.data_ready   = dr;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1)) dutA (.clock(clock), .reset_L(reset_L), .bus(ifA.slave));
  serial_deserializer #(.WIDTH(W), .MSB_FIRST(0)) dutB (.clock(clock), .reset_L(reset_L), .bus(ifB.slave));

  // Reference model: frames as bit queues in arrival order; words are only formed when compared.
  bit mFrame[$];
  bit mHeld[$];
  bit mOut[$];
  bit mHeldPerr, mHasHeld, mOutPerr, mOutValid;

  function automatic logic [W-1:0] assemble(input bit q[$], input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = q[i];
      else     w[i]     = q[i];
    end
    return w;
  endfunction

  function automatic bit frameBit(input logic [W-1:0] w, input bit p, input int i);
    return (i < W) ? w[W-1-i] : p;
  endfunction

  task automatic modelReset();
    mFrame.delete();
    mHeld.delete();
    mOut.delete();
    for (int i = 0; i < W; i++) mOut.push_back(1'b0);
    mHasHeld = 1'b0; mHeldPerr = 1'b0; mOutPerr = 1'b0; mOutValid = 1'b0;
  endtask

  task automatic modelEdge(input bit v, input bit b, input bit a, input bit r);
    bit drain, wasFree, p;
    bit word[$];
    drain   = mOutValid && r;
    wasFree = !mOutValid || drain;
    if (drain) mOutValid = 1'b0;
    if (a) begin
      mFrame.delete();
      mHasHeld = 1'b0;
    end else if (mHasHeld) begin
      if (drain) begin
        mOut = mHeld; mOutPerr = mHeldPerr; mOutValid = 1'b1; mHasHeld = 1'b0;
      end
    end else if (v) begin
      mFrame.push_back(b);
      if (mFrame.size() == FRAME) begin
        p = 1'b0;
        foreach (mFrame[i]) p ^= mFrame[i];
        p = PAR ? p : 1'b0;
        word.delete();
        for (int i = 0; i < W; i++) word.push_back(mFrame[i]);
        mFrame.delete();
        if (wasFree) begin
          mOut = word; mOutPerr = p; mOutValid = 1'b1;
        end else begin
          mHeld = word; mHeldPerr = p; mHasHeld = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input bit b, input bit a, input bit r);
    sv = v; sbit = b; ab = a; dr = r;
    @(posedge clock);
    modelEdge(v, b, a, r);
    #1;
  endtask

  task automatic sendWord(input logic [W-1:0] w, input bit p, input bit r);
    for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, frameBit(w, p, i), 1'b0, r);
  endtask

  task automatic doReset();
    sv = 1'b0; ab = 1'b0; dr = 1'b0;
    reset_L = 1'b0;
    @(posedge clock);
    #2;
    reset_L = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    reset_L = 1'b1;
    #2 reset_L = 1'b0;
    #2;
    total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset valid: got %b want 0", ifA.data_valid); end
    total++; if (ifA.data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset data: got %h want 00", ifA.data_out); end
    total++; if (ifA.bit_count !== '0) begin bad++; $display("[TB] FAIL reset count: got %0d want 0", ifA.bit_count); end
    total++; if (ifA.serial_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset ready: got %b want 1", ifA.serial_ready); end
    total++; if (ifA.parity_err !== 1'b0) begin bad++; $display("[TB] FAIL reset perr: got %b want 0", ifA.parity_err); end
    @(posedge clock);
    #1;
    total++; if (ifB.data_out !== 8'h00) begin bad++; $display("[TB] FAIL reset dataB: got %h want 00", ifB.data_out); end
    #2 reset_L = 1'b1;
    modelReset();
  endtask

  task automatic test_single_word();
    doReset();
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b1, frameBit(8'hA5, ^8'hA5, i), 1'b0, 1'b1);
      if (i < FRAME - 1) begin
        total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL single early_valid bit%0d: got %b want 0", i, ifA.data_valid); end
      end
    end
    total++; if (ifA.data_valid !== 1'b1) begin bad++; $display("[TB] FAIL single valid: got %b want 1", ifA.data_valid); end
    total++; if (ifA.data_out !== 8'hA5) begin bad++; $display("[TB] FAIL single data: got %h want a5", ifA.data_out); end
    total++; if (ifA.parity_err !== 1'b0) begin bad++; $display("[TB] FAIL single perr: got %b want 0", ifA.parity_err); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL single one_cycle: got %b want 0", ifA.data_valid); end
  endtask

  task automatic test_bit_order();
    doReset();
    sendWord(8'hC0, ^8'hC0, 1'b1);
    total++; if (ifA.data_out !== 8'hC0) begin bad++; $display("[TB] FAIL order msb: got %h want c0", ifA.data_out); end
    total++; if (ifB.data_out !== 8'h03) begin bad++; $display("[TB] FAIL order lsb: got %h want 03", ifB.data_out); end
    total++; if (ifB.data_valid !== 1'b1) begin bad++; $display("[TB] FAIL order validB: got %b want 1", ifB.data_valid); end
  endtask

  task automatic test_back_pressure();
    doReset();
    sendWord(8'h11, ^8'h11, 1'b0);
    total++; if (ifA.serial_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp ready1: got %b want 1", ifA.serial_ready); end
    sendWord(8'h22, ^8'h22, 1'b0);
    total++; if (ifA.serial_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp stall_ready: got %b want 0", ifA.serial_ready); end
    total++; if (ifA.data_out !== 8'h11) begin bad++; $display("[TB] FAIL bp held: got %h want 11", ifA.data_out); end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (ifA.bit_count !== '0) begin bad++; $display("[TB] FAIL bp refused: got %0d want 0", ifA.bit_count); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (ifA.data_out !== 8'h22) begin bad++; $display("[TB] FAIL bp second: got %h want 22", ifA.data_out); end
    total++; if (ifA.data_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp second_valid: got %b want 1", ifA.data_valid); end
    total++; if (ifA.serial_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp ready_back: got %b want 1", ifA.serial_ready); end
    sendWord(8'h33, ^8'h33, 1'b1);
    total++; if (ifA.data_out !== 8'h33) begin bad++; $display("[TB] FAIL bp third: got %h want 33", ifA.data_out); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    total++; if (ifA.bit_count !== CW'(5)) begin bad++; $display("[TB] FAIL abort partial: got %0d want 5", ifA.bit_count); end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (ifA.bit_count !== '0) begin bad++; $display("[TB] FAIL abort cleared: got %0d want 0", ifA.bit_count); end
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b1, frameBit(8'h3C, ^8'h3C, i), 1'b0, 1'b1);
      if (i < FRAME - 1) begin
        total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort spurious bit%0d: got %b want 0", i, ifA.data_valid); end
      end
    end
    total++; if (ifA.data_out !== 8'h3C) begin bad++; $display("[TB] FAIL abort word: got %h want 3c", ifA.data_out); end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    total++; if (ifA.bit_count !== '0) begin bad++; $display("[TB] FAIL abort same_cycle: got %0d want 0", ifA.bit_count); end
    sendWord(8'h11, ^8'h11, 1'b0);
    sendWord(8'h22, ^8'h22, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (ifA.serial_ready !== 1'b1) begin bad++; $display("[TB] FAIL abort stall_ready: got %b want 1", ifA.serial_ready); end
    total++; if (ifA.data_out !== 8'h11) begin bad++; $display("[TB] FAIL abort out_kept: got %h want 11", ifA.data_out); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort stall_dropped: got %b want 0", ifA.data_valid); end
  endtask

  task automatic test_mid_reset();
    doReset();
    sendWord(8'h5A, ^8'h5A, 1'b0);
    total++; if (ifA.data_out !== 8'h5A) begin bad++; $display("[TB] FAIL rst pending: got %h want 5a", ifA.data_out); end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (ifA.bit_count !== CW'(4)) begin bad++; $display("[TB] FAIL rst partial: got %0d want 4", ifA.bit_count); end
    #2 reset_L = 1'b0;
    #1;
    total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst valid: got %b want 0", ifA.data_valid); end
    total++; if (ifA.data_out !== 8'h00) begin bad++; $display("[TB] FAIL rst data: got %h want 00", ifA.data_out); end
    total++; if (ifA.bit_count !== '0) begin bad++; $display("[TB] FAIL rst count: got %0d want 0", ifA.bit_count); end
    modelReset();
    @(posedge clock);
    #2 reset_L = 1'b1;
    sendWord(8'hFF, ^8'hFF, 1'b1);
    total++; if (ifA.data_out !== 8'hFF) begin bad++; $display("[TB] FAIL rst after: got %h want ff", ifA.data_out); end
    total++; if (ifA.data_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst after_valid: got %b want 1", ifA.data_valid); end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef SERIAL_DESER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words[3] = '{8'hA5, 8'hA5, 8'h01};
    bit           pbits[3] = '{1'b0, 1'b1, 1'b1};
    bit           perrs[3] = '{1'b0, 1'b1, 1'b0};
    doReset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) applyStimulus(1'b1, frameBit(words[k], 1'b0, i), 1'b0, 1'b1);
      total++; if (ifA.bit_count !== CW'(W)) begin bad++; $display("[TB] FAIL parity count%0d: got %0d want %0d", k, ifA.bit_count, W); end
      total++; if (ifA.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL parity early%0d: got %b want 0", k, ifA.data_valid); end
      applyStimulus(1'b1, pbits[k], 1'b0, 1'b1);
      total++; if (ifA.data_valid !== 1'b1) begin bad++; $display("[TB] FAIL parity valid%0d: got %b want 1", k, ifA.data_valid); end
      total++; if (ifA.data_out !== words[k]) begin bad++; $display("[TB] FAIL parity data%0d: got %h want %h", k, ifA.data_out, words[k]); end
      total++; if (ifA.parity_err !== perrs[k]) begin bad++; $display("[TB] FAIL parity perr%0d: got %b want %b", k, ifA.parity_err, perrs[k]); end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask
`endif

  task automatic test_random();
    int pct[4] = '{90, 30, 5, 70};
    logic [W-1:0] expA, expB;
    doReset();
    for (int c = 0; c < 800; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 49) == 0,
                    $urandom_range(0, 99) < pct[c / 200]);
      expA = assemble(mOut, 1'b1);
      expB = assemble(mOut, 1'b0);
      total++; if (ifA.data_valid !== mOutValid) begin bad++; $display("[TB] FAIL rand valid c%0d: got %b want %b", c, ifA.data_valid, mOutValid); end
      total++; if (ifA.serial_ready !== !mHasHeld) begin bad++; $display("[TB] FAIL rand ready c%0d: got %b want %b", c, ifA.serial_ready, !mHasHeld); end
      total++; if (ifA.bit_count !== CW'(mFrame.size())) begin bad++; $display("[TB] FAIL rand count c%0d: got %0d want %0d", c, ifA.bit_count, mFrame.size()); end
      total++; if (ifA.parity_err !== mOutPerr) begin bad++; $display("[TB] FAIL rand perr c%0d: got %b want %b", c, ifA.parity_err, mOutPerr); end
      total++; if (ifA.data_out !== expA) begin bad++; $display("[TB] FAIL rand dataA c%0d: got %h want %h", c, ifA.data_out, expA); end
      total++; if (ifB.data_out !== expB) begin bad++; $display("[TB] FAIL rand dataB c%0d: got %h want %h", c, ifB.data_out, expB); end
      total++; if (ifB.data_valid !== mOutValid) begin bad++; $display("[TB] FAIL rand validB c%0d: got %b want %b", c, ifB.data_valid, mOutValid); end
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_single_word();
    test_bit_order();
    test_back_pressure();
    test_abort();
    test_mid_reset();
`ifdef SERIAL_DESER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
